// File: rtl/stream_to_vector.sv
// stream_to_vector
//   Deserializer that packs a stream of DWIDTH-bit samples into a
//   NUM_INPUTS-lane vector (lane k at bits [k*DWIDTH +: DWIDTH], first
//   accepted sample in lane 0). Double-buffered: a fill register collects
//   samples while the output register holds the last completed vector.
//   An accepted sample with i_dat_last closes the vector early; lanes that
//   were never written read zero.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   i_dat        in   input sample
//   i_dat_valid  in   i_dat valid this cycle
//   i_dat_last   in   accepted sample closes the current vector
//   o_dat_ready  out  sample accepted this cycle when valid (registered)
//   o_vec        out  packed output vector
//   o_vec_count  out  number of filled lanes in o_vec (1..NUM_INPUTS)
//   o_vec_valid  out  o_vec / o_vec_count valid
//   i_vec_ready  in   downstream consumes o_vec this cycle
module stream_to_vector #(
    parameter int NUM_INPUTS = 16,
    parameter int DWIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DWIDTH-1:0]            i_dat,
    input  logic                         i_dat_valid,
    input  logic                         i_dat_last,
    output logic                         o_dat_ready,
    output logic [NUM_INPUTS*DWIDTH-1:0] o_vec,
    output logic [$clog2(NUM_INPUTS):0]  o_vec_count,
    output logic                         o_vec_valid,
    input  logic                         i_vec_ready
);

    localparam int IW = $clog2(NUM_INPUTS);
    localparam int CW = IW + 1;
    localparam int VW = NUM_INPUTS * DWIDTH;

    typedef enum logic {
        FILL,
        PEND
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   fill_q, fill_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            rdy_q, rdy_d;

    logic            accept;
    logic            pop;
    logic            complete;
    logic            slot_free;
    logic [VW-1:0]   fill_written;

    // rdy_q is only ever set while in FILL, so it fully qualifies acceptance.
    assign accept    = i_dat_valid && rdy_q;
    assign pop       = valid_q && i_vec_ready;
    assign complete  = accept && ((idx_q == IW'(NUM_INPUTS - 1)) || i_dat_last);
    assign slot_free = !valid_q || pop;

    always_comb begin
        fill_written = fill_q;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (idx_q == IW'(k)) begin
                fill_written[k*DWIDTH +: DWIDTH] = i_dat;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (complete && !slot_free) state_d = PEND;
            PEND: if (pop)                    state_d = FILL;
            default:                          state_d = FILL;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        fill_d  = fill_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        count_d = count_q;
        valid_d = valid_q;
        rdy_d   = (state_d == FILL);

        if (pop) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (complete && slot_free) begin
                    vec_d   = fill_written;
                    count_d = CW'(idx_q) + CW'(1);
                    valid_d = 1'b1;
                    fill_d  = '0;
                    idx_d   = '0;
                end else if (complete) begin
                    // Held in PEND; idx stays on the last lane so the count
                    // can still be formed as idx+1 at transfer time.
                    fill_d = fill_written;
                end else if (accept) begin
                    fill_d = fill_written;
                    idx_d  = idx_q + IW'(1);
                end
            end
            PEND: begin
                if (pop) begin
                    vec_d   = fill_q;
                    count_d = CW'(idx_q) + CW'(1);
                    valid_d = 1'b1;
                    fill_d  = '0;
                    idx_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            count_q <= count_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_vec       = vec_q;
    assign o_vec_count = count_q;
    assign o_vec_valid = valid_q;
    assign o_dat_ready = rdy_q;

endmodule

// File: tb/tb_stream_to_vector.sv
module tb_stream_to_vector;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int VW = N * DW;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   i_dat;
    logic            i_dat_valid;
    logic            i_dat_last;
    logic            o_dat_ready;
    logic [VW-1:0]   o_vec;
    logic [4:0]      o_vec_count;
    logic            o_vec_valid;
    logic            i_vec_ready;

    int checks = 0;
    int errors = 0;

    stream_to_vector #(
        .NUM_INPUTS(N),
        .DWIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_dat(i_dat),
        .i_dat_valid(i_dat_valid),
        .i_dat_last(i_dat_last),
        .o_dat_ready(o_dat_ready),
        .o_vec(o_vec),
        .o_vec_count(o_vec_count),
        .o_vec_valid(o_vec_valid),
        .i_vec_ready(i_vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        i_dat       = d;
        i_dat_valid = 1'b1;
        i_dat_last  = last;
        cyc();
        i_dat_valid = 1'b0;
        i_dat_last  = 1'b0;
    endtask

    // Lanes 0..n-1 hold base+k, the rest zero.
    function automatic logic [VW-1:0] ramp(input int base, input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    task automatic drain();
        i_dat_valid = 1'b0;
        i_vec_ready = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_dat = '0; i_dat_valid = 1'b0; i_dat_last = 1'b0; i_vec_ready = 1'b0;
        cyc(); cyc();
        checks++;
        if (o_vec !== '0 || o_vec_count !== 5'd0 || o_vec_valid !== 1'b0 || o_dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: vec=%h cnt=%0d vld=%b rdy=%b, required all zero",
                     o_vec, o_vec_count, o_vec_valid, o_dat_ready);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (o_dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b required 0", o_dat_ready);
        end
        cyc();
        checks++;
        if (o_dat_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", o_dat_ready);
        end
    endtask

    task automatic test_continuous();
        logic exp_valid;
        i_vec_ready = 1'b1;
        for (int s = 0; s < 32; s++) begin
            checks++;
            if (o_dat_ready !== 1'b1) begin
                errors++;
                $display("FAIL cont_ready s=%0d: got %b required 1", s, o_dat_ready);
            end
            send(DW'(s), 1'b0);
            exp_valid = (s == 15 || s == 31);
            checks++;
            if (o_vec_valid !== exp_valid) begin
                errors++;
                $display("FAIL cont_valid s=%0d: got %b required %b", s, o_vec_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (o_vec !== ramp(s - 15, 16) || o_vec_count !== 5'd16) begin
                    errors++;
                    $display("FAIL cont_vec s=%0d: got %h cnt=%0d required %h cnt=16",
                             s, o_vec, o_vec_count, ramp(s - 15, 16));
                end
            end
        end
        drain();
        checks++;
        if (o_vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_pop: vld=%b required 0", o_vec_valid);
        end
    endtask

    task automatic test_backpressure();
        i_vec_ready = 1'b0;
        for (int s = 0; s < 32; s++) begin
            checks++;
            if (o_dat_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready s=%0d: got %b required 1", s, o_dat_ready);
            end
            send(DW'(s), 1'b0);
        end
        checks++;
        if (o_dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_drop: got %b required 0", o_dat_ready);
        end
        // Sample 32 offered while stalled: must not be taken, vector must hold.
        i_dat = 8'd32; i_dat_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (o_vec !== ramp(0, 16) || o_vec_valid !== 1'b1 || o_dat_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d: vec=%h vld=%b rdy=%b required %h 1 0",
                         c, o_vec, o_vec_valid, o_dat_ready, ramp(0, 16));
            end
        end
        i_vec_ready = 1'b1;
        cyc();
        i_vec_ready = 1'b0;
        checks++;
        if (o_vec !== ramp(16, 16) || o_vec_count !== 5'd16 || o_vec_valid !== 1'b1 || o_dat_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_transfer: vec=%h cnt=%0d vld=%b rdy=%b required %h 16 1 1",
                     o_vec, o_vec_count, o_vec_valid, o_dat_ready, ramp(16, 16));
        end
        for (int s = 32; s <= 40; s++) send(DW'(s), s == 40);
        checks++;
        if (o_dat_ready !== 1'b0 || o_vec !== ramp(16, 16)) begin
            errors++;
            $display("FAIL bp_second_pend: rdy=%b vec=%h required 0 %h", o_dat_ready, o_vec, ramp(16, 16));
        end
        i_vec_ready = 1'b1;
        cyc();
        i_vec_ready = 1'b0;
        checks++;
        if (o_vec !== ramp(32, 9) || o_vec_count !== 5'd9 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_lane0: vec=%h cnt=%0d vld=%b required %h 9 1",
                     o_vec, o_vec_count, o_vec_valid, ramp(32, 9));
        end
        drain();
        checks++;
        if (o_vec_valid !== 1'b0 || o_dat_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: vld=%b rdy=%b required 0 1", o_vec_valid, o_dat_ready);
        end
    endtask

    task automatic test_early_close();
        i_vec_ready = 1'b1;
        for (int s = 1; s <= 5; s++) send(DW'(s), s == 5);
        checks++;
        if (o_vec !== ramp(1, 5) || o_vec_count !== 5'd5 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_close: vec=%h cnt=%0d vld=%b required %h 5 1",
                     o_vec, o_vec_count, o_vec_valid, ramp(1, 5));
        end
        send(8'hAB, 1'b1);
        checks++;
        if (o_vec !== ramp(8'hAB, 1) || o_vec_count !== 5'd1 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL close_first: vec=%h cnt=%0d required %h 1", o_vec, o_vec_count, ramp(8'hAB, 1));
        end
        for (int k = 0; k < 16; k++) send(DW'(8'hC0 + k), k == 15);
        checks++;
        if (o_vec !== ramp(8'hC0, 16) || o_vec_count !== 5'd16) begin
            errors++;
            $display("FAIL close_16th: vec=%h cnt=%0d required %h 16", o_vec, o_vec_count, ramp(8'hC0, 16));
        end
        drain();
        i_dat = 8'hEE; i_dat_valid = 1'b0; i_dat_last = 1'b1;
        cyc(); cyc();
        i_dat_last = 1'b0;
        checks++;
        if (o_vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL last_no_valid: vld=%b required 0", o_vec_valid);
        end
        for (int k = 0; k < 16; k++) begin
            send(DW'(8'h20 + k), 1'b0);
            if (k == 14) begin
                checks++;
                if (o_vec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL last_no_valid_early: vld=%b required 0", o_vec_valid);
                end
            end
        end
        checks++;
        if (o_vec !== ramp(8'h20, 16) || o_vec_count !== 5'd16 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL last_no_valid_vec: vec=%h cnt=%0d required %h 16", o_vec, o_vec_count, ramp(8'h20, 16));
        end
        drain();
    endtask

    task automatic test_valid_gaps();
        i_vec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(DW'(k), 1'b0);
            if (k < 15) begin
                i_dat = 8'hFF; i_dat_last = 1'b1;
                cyc();
                i_dat_last = 1'b0;
            end
        end
        checks++;
        if (o_vec !== ramp(0, 16) || o_vec_count !== 5'd16 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_gaps: vec=%h cnt=%0d vld=%b required %h 16 1",
                     o_vec, o_vec_count, o_vec_valid, ramp(0, 16));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        i_vec_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(DW'(8'h10 + k), 1'b0);
        for (int k = 0; k < 7; k++) send(DW'(8'h50 + k), 1'b0);
        checks++;
        if (o_vec_valid !== 1'b1 || o_vec !== ramp(8'h10, 16)) begin
            errors++;
            $display("FAIL rstmid_pre: vld=%b vec=%h required 1 %h", o_vec_valid, o_vec, ramp(8'h10, 16));
        end
        rst = 1'b1;
        #2;
        checks++;
        if (o_vec_valid !== 1'b0 || o_vec !== '0 || o_vec_count !== 5'd0 || o_dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: vld=%b vec=%h cnt=%0d rdy=%b required all zero",
                     o_vec_valid, o_vec, o_vec_count, o_dat_ready);
        end
        cyc();
        rst = 1'b0;
        cyc();
        i_vec_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(DW'(8'h60 + k), 1'b0);
        checks++;
        if (o_vec !== ramp(8'h60, 16) || o_vec_count !== 5'd16 || o_vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: vec=%h cnt=%0d vld=%b required %h 16 1",
                     o_vec, o_vec_count, o_vec_valid, ramp(8'h60, 16));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_early_close();
        test_valid_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
